// File: rtl/ud_seg_scan_if.sv
// Display-side bundle for the two-digit scan driver: counter value and glyph in,
// digit select and segment bus out.
interface ud_seg_scan_if;
    logic       en;
    logic [3:0] count;
    logic [6:0] dir_seg;
    logic [1:0] an;
    logic [6:0] seg;

    modport master (output en, output count, output dir_seg, input an, input seg);
    modport slave  (input en, input count, input dir_seg, output an, output seg);
endinterface

// File: rtl/ud_seg_scan.sv
// Two-digit multiplexed seven-segment scan driver: hex value on digit 0, direction
// glyph on digit 1, frame-synchronous input capture and blink-on-wrap for digit 0.
module ud_seg_scan #(
    parameter int DIV          = 4,
    parameter int BLINK_FRAMES = 8
) (
    input  logic          clk,
    input  logic          reset,
    ud_seg_scan_if.slave  bus
);
    localparam int             CW         = $clog2(DIV);
    localparam logic [CW-1:0]  TICK_LAST  = CW'(DIV - 1);
    localparam logic [7:0]     BLINK_LOAD = 8'(BLINK_FRAMES);

    logic [CW-1:0] tick_cnt_reg,  tick_cnt_next;
    logic          slot_reg,      slot_next;
    logic [3:0]    count_l_reg,   count_l_next;
    logic [6:0]    dir_seg_l_reg, dir_seg_l_next;
    logic [7:0]    blink_cnt_reg, blink_cnt_next;
    logic          primed_reg,    primed_next;
    logic [1:0]    an_reg,        an_next;
    logic [6:0]    seg_reg,       seg_next;

    logic       tick;
    logic       frame_start;
    logic       wrap;
    logic       show_value;
    logic       show_glyph;
    logic [6:0] font_seg;

    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h3F;
            4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;
            4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;
            4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;
            4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;
            4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;
            4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;
            4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    always_comb begin
        tick        = (tick_cnt_reg == TICK_LAST);
        frame_start = tick & slot_reg;
        // Only a jump between the two extremes counts; the very first capture has no valid predecessor.
        wrap        = primed_reg &&
                      (((count_l_reg == 4'hF) && (bus.count == 4'h0)) ||
                       ((count_l_reg == 4'h0) && (bus.count == 4'hF)));

        tick_cnt_next  = tick ? '0 : CW'(tick_cnt_reg + 1'b1);
        slot_next      = slot_reg ^ tick;
        count_l_next   = count_l_reg;
        dir_seg_l_next = dir_seg_l_reg;
        blink_cnt_next = blink_cnt_reg;
        primed_next    = primed_reg;

        if (frame_start) begin
            count_l_next   = bus.count;
            dir_seg_l_next = bus.dir_seg;
            primed_next    = 1'b1;
            if (wrap)
                blink_cnt_next = BLINK_LOAD;
            else if (blink_cnt_reg != 8'd0)
                blink_cnt_next = blink_cnt_reg - 8'd1;
        end

        font_seg   = hex_font(count_l_reg);
        show_value = bus.en & ~slot_reg & ~blink_cnt_reg[0];
        show_glyph = bus.en & slot_reg;
        an_next    = {show_glyph, show_value};
    end

    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_seg
            assign seg_next[gi] = (show_value & font_seg[gi]) | (show_glyph & dir_seg_l_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt_reg  <= '0;
            slot_reg      <= 1'b0;
            count_l_reg   <= 4'h0;
            dir_seg_l_reg <= 7'h00;
            blink_cnt_reg <= 8'd0;
            primed_reg    <= 1'b0;
            an_reg        <= 2'b00;
            seg_reg       <= 7'h00;
        end else begin
            tick_cnt_reg  <= tick_cnt_next;
            slot_reg      <= slot_next;
            count_l_reg   <= count_l_next;
            dir_seg_l_reg <= dir_seg_l_next;
            blink_cnt_reg <= blink_cnt_next;
            primed_reg    <= primed_next;
            an_reg        <= an_next;
            seg_reg       <= seg_next;
        end
    end

    assign bus.an  = an_reg;
    assign bus.seg = seg_reg;
endmodule

// File: tb/tb_ud_seg_scan.sv
// Bench for ud_seg_scan: frame-level reference model compared every cycle, plus
// directed and randomized stimulus with a few literal expectations.
module tb_ud_seg_scan;
    localparam int DIV   = 4;
    localparam int BF    = 4;
    localparam int FRAME = 2 * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ud_seg_scan_if bus ();

    ud_seg_scan #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m = edges since reset release; slot = (m / DIV) % 2; a frame starts on every
    // edge that brings m to a multiple of 2*DIV.
    int         m;
    logic [3:0] cap_count;
    logic [6:0] cap_glyph;
    int         blink;
    bit         primed;
    bit         wrap;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m = 0; cap_count = 4'h0; cap_glyph = 7'h00; blink = 0; primed = 0;
                exp_an = 2'b00; exp_seg = 7'h00;
            end else begin
                exp_an = 2'b00; exp_seg = 7'h00;
                if (bus.en) begin
                    if (((m / DIV) % 2) == 0) begin
                        if ((blink % 2) == 0) begin
                            exp_an = 2'b01; exp_seg = font[cap_count];
                        end
                    end else begin
                        exp_an = 2'b10; exp_seg = cap_glyph;
                    end
                end
                m++;
                if ((m % FRAME) == 0) begin
                    wrap = primed && ((cap_count == 4'hF && bus.count == 4'h0) ||
                                      (cap_count == 4'h0 && bus.count == 4'hF));
                    cap_count = bus.count;
                    cap_glyph = bus.dir_seg;
                    blink = wrap ? BF : (blink > 0 ? blink - 1 : 0);
                    primed = 1;
                end
            end
            @(negedge clk);
            check("model_an", 8'(bus.an), 8'(exp_an));
            check("model_seg", 8'(bus.seg), 8'(exp_seg));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int r;
        bus.en = 1'b1; bus.count = 4'h5; bus.dir_seg = 7'h3E;
        cycles(3);
        reset = 1'b0;
        cycles(1);
        check("first_an", 8'(bus.an), 8'h01);
        check("first_seg", 8'(bus.seg), 8'h3F);
        cycles(8);
        check("val_an", 8'(bus.an), 8'h01);
        check("val_seg", 8'(bus.seg), 8'h6D);
        cycles(4);
        check("glyph_an", 8'(bus.an), 8'h02);
        check("glyph_seg", 8'(bus.seg), 8'h3E);

        // Font sweep, one value per frame; ends with F captured.
        for (int v = 0; v < 16; v++) begin
            bus.count = 4'(v);
            cycles(FRAME);
        end

        // Up wrap F->0, then down wrap 0->F.
        bus.count = 4'h0;
        cycles(12);
        check("blink_blank_an", 8'(bus.an), 8'h00);
        cycles(8 * FRAME - 12);
        bus.count = 4'hF;
        cycles(8 * FRAME);

        // First capture after reset is F: no blink.
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(9);
        check("primed_an", 8'(bus.an), 8'h01);
        check("primed_seg", 8'(bus.seg), 8'h71);
        cycles(2 * FRAME);

        // 3 -> 7 -> 3 inside one frame.
        bus.count = 4'h3;
        cycles(FRAME + 2);
        bus.count = 4'h7;
        cycles(2);
        bus.count = 4'h3;
        cycles(2 * FRAME);

        // Display disable mid-frame.
        bus.en = 1'b0;
        cycles(1);
        check("en_off_an", 8'(bus.an), 8'h00);
        check("en_off_seg", 8'(bus.seg), 8'h00);
        cycles(9);
        bus.en = 1'b1;
        cycles(2 * FRAME);

        // Reset during a blink, mid-slot.
        bus.count = 4'hF;
        cycles(2 * FRAME);
        bus.count = 4'h0;
        cycles(FRAME + 3);
        reset = 1'b1;
        cycles(1);
        check("rst_an", 8'(bus.an), 8'h00);
        check("rst_seg", 8'(bus.seg), 8'h00);
        reset = 1'b0;
        cycles(2 * FRAME);

        // Randomized traffic biased toward the wrap values.
        repeat (800) begin
            r = $urandom_range(0, 99);
            if (r < 20)
                bus.count = ($urandom_range(0, 1) != 0) ? 4'hF : 4'h0;
            else if (r < 30)
                bus.count = 4'($urandom_range(0, 15));
            if ((r % 17) == 0)
                bus.dir_seg = 7'($urandom_range(0, 127));
            bus.en = ($urandom_range(0, 19) != 0);
            reset = ($urandom_range(0, 149) == 0);
            cycles(1);
        end
        reset = 1'b0;
        bus.en = 1'b1;
        cycles(FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ud_seg_scan.md
# ud_seg_scan

Two-digit multiplexed seven-segment scan driver that sits directly downstream of the up/down counter. It takes the counter's 4-bit value and its 7-bit direction glyph. It time-multiplexes them onto one shared segment bus, with the hex value on digit 0 and the glyph on digit 1. Inputs are captured only at frame boundaries, so the display never tears. A count wrap (F↔0) makes the value digit blink for a programmable number of frames.

## Interface
- DIV, 4: clock cycles per digit slot; legal range ≥ 2; counter width $clog2(DIV).
- BLINK_FRAMES, 8: frames of blink after a wrap; legal range 0..255; 0 disables blinking.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- en  in  1  display enable; 0 blanks the outputs, but internal scanning continues.
- count  in  4  counter value to display as hex.
- dir_seg  in  7  direction glyph, passed through unchanged on digit 1.
- an  out  2  digit select, active-high, one-hot or 00 (blank); an[0] = value digit, an[1] = glyph digit.
- seg  out  7  segments, active-high; seg[0]=a … seg[6]=g.

## Operation
- Prescaler `tick_cnt` counts 0..DIV-1 and wraps. `tick` is asserted in the cycle where tick_cnt==DIV-1.
- `slot` (1 bit) toggles on tick. A frame is slot 0 followed by slot 1, i.e. 2·DIV cycles.
- Frame start is tick while slot==1. In that cycle:
  - count_l ← count and dir_seg_l ← dir_seg.
  - The previous count_l value is used for wrap detection.
- Wrap is (old==F && new==0) || (old==0 && new==F), qualified by a `primed` flag.
  - `primed` is cleared by reset and set at the first frame start.
  - Wrap detection is suppressed at that first capture.
- Blink counter `blink_cnt` (8 bit), updated at frame start:
  - Wrap → load BLINK_FRAMES.
  - Otherwise, if nonzero → decrement.
  - Wrap while already blinking reloads BLINK_FRAMES.
- Digit 0 is blanked while blink_cnt[0]==1. With BLINK_FRAMES=8 the frames run visible/blank/… ending visible at blink_cnt=0, giving 4 blank frames.
- Output decode, registered:
  - en==0 → an=00, seg=0000000.
  - slot 0, not blanked → an=01, seg=hex(count_l).
  - slot 0, blanked → an=00, seg=0000000.
  - slot 1 → an=10, seg=dir_seg_l.
- Hex font (seg[6:0], hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- No other state. Inputs between frame starts are ignored. A multi-step change within one frame is judged only on the endpoints.

## Timing
- Reset values: tick_cnt=0, slot=0, count_l=0, dir_seg_l=0, blink_cnt=0, primed=0, an=00, seg=0000000.
- Reset asserted mid-frame forces all of the above on the next edge, regardless of en or slot.
- Outputs are registered with one cycle of latency from internal state.
  - Cycle 1 after reset release: an=01, seg=3F (0 is the reset value of count_l).
- Slot changes at edge k·DIV after reset release. The output reflects it one cycle later.
- Captured input appears on an/seg at the first cycle of slot 0 (plus 1 output register), i.e. ≤ 2·DIV+1 cycles after the input changes.
- en acts on the output register only, so it also has 1-cycle latency.
- Simultaneous events at frame start (capture, wrap, blink decrement) resolve in the same edge as listed in Operation.

## Test plan
- DIV=4: reset 3 cycles, count=5, dir_seg=3E, en=1.
  - 1 cycle after release: an=01, seg=3F.
  - After the first frame start: an=01/seg=6D for 4 cycles, alternating with an=10/seg=3E for 4 cycles.
- Sweep count through 0..F, one value per frame → digit-0 seg matches the 16-entry font exactly.
- DIV=4, BLINK_FRAMES=4: count F then 0 in successive frames → digit 0 blank in 2 frames (blink_cnt 3, 1), visible otherwise; digit 1 unaffected. Repeat with 0→F for the down-direction wrap.
- First capture after reset with count=F → no blink (primed gating). count changes 3→7→3 inside one frame → no visible 7 and no blink.
- en=0 for 10 cycles mid-frame → an=00, seg=00 one cycle after en falls. Scan phase continues, so after en rises the output resumes at the slot matching elapsed cycles.
- Reset asserted during a blink and mid-slot → next cycle all outputs 00 and blink cleared; scan restarts from slot 0.
